// File: rtl/vram_scanout_arbiter_if.sv
// Beam, host and VRAM signals of the scanout arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_scanout_arbiter_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [9:0]        hpos;
    logic [9:0]        vpos;
    logic              visible;
    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_ready;
    logic              host_rvalid;
    logic [7:0]        host_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;

    modport slave (
        input  hpos, vpos, visible, host_valid, host_we, host_addr, host_wdata, ram_rdata,
        output host_ready, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata, r, g, b
    );

    modport master (
        output hpos, vpos, visible, host_valid, host_we, host_addr, host_wdata, ram_rdata,
        input  host_ready, host_rvalid, host_rdata, ram_en, ram_we, ram_addr, ram_wdata, r, g, b
    );
endinterface

// File: rtl/vram_scanout_arbiter.sv
// Single-port VRAM owner: fetches one RGB332 cell per scaled pixel for the beam, expands it to
// 8-bit RGB with a fixed 2-cycle latency, and hands every non-fetch RAM cycle to the host port.
module vram_scanout_arbiter #(
    parameter int unsigned H_CELLS    = 160,
    parameter int unsigned V_CELLS    = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ADDR_W     = 15
) (
    input logic                   i_clk,
    input logic                   i_rst,
    vram_scanout_arbiter_if.slave bus
);

    localparam int unsigned CELLS    = H_CELLS * V_CELLS;
    localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_LOG2) - 1);

    logic [9:0]        col;
    logic [9:0]        row;
    logic              vf;
    logic              host_ready;
    logic              host_xfer;
    logic              host_in_range;
    logic [ADDR_W-1:0] video_addr;

    assign col = bus.hpos >> SCALE_LOG2;
    assign row = bus.vpos >> SCALE_LOG2;

    // Fetch only on the first screen pixel of each cell inside the bitmap.
    assign vf = !i_rst && bus.visible && ((bus.hpos & SUB_MASK) == '0)
                && (32'(col) < H_CELLS) && (32'(row) < V_CELLS);

    assign video_addr    = ADDR_W'(row) * ADDR_W'(H_CELLS) + ADDR_W'(col);
    assign host_ready    = !i_rst && !vf;
    assign host_xfer     = bus.host_valid && host_ready;
    assign host_in_range = 32'(bus.host_addr) < CELLS;

    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (vf) begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = video_addr;
        end else if (host_xfer) begin
            // Out-of-range requests are accepted but never reach the RAM.
            bus.ram_en    = host_in_range;
            bus.ram_we    = host_in_range && bus.host_we;
            bus.ram_addr  = bus.host_addr;
            bus.ram_wdata = bus.host_wdata;
        end
    end

    logic       fetch_q;
    logic       rd_q;
    logic       rd_oor_q;
    logic       vis_q;
    logic [7:0] pix_q;
    logic [7:0] pix_d;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic       rvalid_q;
    logic [7:0] rdata_q;

    assign pix_d = fetch_q ? bus.ram_rdata : pix_q;

    // vis_q is the first visible delay stage; the gated RGB register is the second.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_q  <= 1'b0;
            rd_q     <= 1'b0;
            rd_oor_q <= 1'b0;
            vis_q    <= 1'b0;
            pix_q    <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            fetch_q  <= vf;
            rd_q     <= host_xfer && !bus.host_we;
            rd_oor_q <= !host_in_range;
            vis_q    <= bus.visible;
            pix_q    <= pix_d;
            if (vis_q) begin
                r_q <= {pix_d[7:5], pix_d[7:5], pix_d[7:6]};
                g_q <= {pix_d[4:2], pix_d[4:2], pix_d[4:3]};
                b_q <= {pix_d[1:0], pix_d[1:0], pix_d[1:0], pix_d[1:0]};
            end else begin
                r_q <= '0;
                g_q <= '0;
                b_q <= '0;
            end
            rvalid_q <= rd_q;
            if (rd_q) begin
                rdata_q <= rd_oor_q ? 8'h00 : bus.ram_rdata;
            end
        end
    end

    assign bus.host_ready  = host_ready;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rdata_q;
    assign bus.r           = r_q;
    assign bus.g           = g_q;
    assign bus.b           = b_q;

endmodule

// File: tb/tb_vram_scanout_arbiter.sv
// Randomised bench for vram_scanout_arbiter: a cycle-indexed behavioural model predicts every
// output each cycle, and a few directed sequences pin literal values.
module tb_vram_scanout_arbiter;

    localparam int unsigned H_CELLS = 160;
    localparam int unsigned V_CELLS = 120;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned CELLS = H_CELLS * V_CELLS;
    localparam int unsigned CS = 1 << SCALE_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vram_scanout_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    vram_scanout_arbiter #(
        .H_CELLS(H_CELLS),
        .V_CELLS(V_CELLS),
        .SCALE_LOG2(SCALE_LOG2),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench-side VRAM: synchronous write, registered read.
    logic [7:0] mem [0:32767] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    function automatic bit f_vf(input logic [9:0] h, input logic [9:0] v, input logic vis);
        return vis && (h % CS == 0) && (h / CS < H_CELLS) && (v / CS < V_CELLS);
    endfunction

    function automatic int unsigned f_addr(input logic [9:0] h, input logic [9:0] v);
        return (v / CS) * H_CELLS + h / CS;
    endfunction

    function automatic logic [23:0] f_rgb(input logic [7:0] p);
        int unsigned rr = p >> 5;
        int unsigned gg = (p >> 2) & 7;
        int unsigned bb = p & 3;
        return {8'((rr << 5) | (rr << 2) | (rr >> 1)), 8'((gg << 5) | (gg << 2) | (gg >> 1)),
                8'(bb * 8'h55)};
    endfunction

    // Model state: shadow memory and expectations indexed by the cycle they appear in.
    logic [7:0] shadow [0:32767] = '{default: 8'h00};
    logic [7:0] m_pix = 8'h00;
    logic       e_vis [0:3] = '{default: 1'b0};
    logic [7:0] e_pix [0:3] = '{default: 8'h00};
    logic       e_rv  [0:3] = '{default: 1'b0};
    logic [7:0] e_rd  [0:3] = '{default: 8'h00};
    int         m_slot;
    bit         m_vf;
    bit         m_xfer;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                e_vis[i] = 1'b0;
                e_pix[i] = 8'h00;
                e_rv[i]  = 1'b0;
                e_rd[i]  = 8'h00;
            end
            m_pix = 8'h00;
        end else begin
            m_slot = (cyc + 2) % 4;
            m_vf   = f_vf(bus.hpos, bus.vpos, bus.visible);
            m_xfer = bus.host_valid && !m_vf;
            if (m_vf) m_pix = shadow[f_addr(bus.hpos, bus.vpos)];
            e_vis[m_slot] = bus.visible;
            e_pix[m_slot] = m_pix;
            e_rv[m_slot]  = m_xfer && !bus.host_we;
            e_rd[m_slot]  = (32'(bus.host_addr) < CELLS) ? shadow[bus.host_addr] : 8'h00;
            if (m_xfer && bus.host_we && 32'(bus.host_addr) < CELLS)
                shadow[bus.host_addr] = bus.host_wdata;
        end
        cyc++;
    end

    // Per-cycle compare against the model, sampled mid-cycle.
    logic [7:0] hold = 8'h00;
    bit         c_vf;
    bit         c_xfer;
    bit         c_in;
    int         c_slot;

    always @(negedge clk) begin
        c_vf   = f_vf(bus.hpos, bus.vpos, bus.visible);
        c_xfer = bus.host_valid && !c_vf;
        c_in   = 32'(bus.host_addr) < CELLS;
        c_slot = cyc % 4;
        if (rst) begin
            hold = 8'h00;
            chk("rst_ready", 32'(bus.host_ready), 0);
            chk("rst_ram_en", 32'(bus.ram_en), 0);
            chk("rst_rvalid", 32'(bus.host_rvalid), 0);
            chk("rst_rdata", 32'(bus.host_rdata), 0);
            chk("rst_rgb", 32'({bus.r, bus.g, bus.b}), 0);
        end else begin
            chk("host_ready", 32'(bus.host_ready), 32'(!c_vf));
            chk("ram_en", 32'(bus.ram_en), 32'(c_vf || (c_xfer && c_in)));
            chk("ram_we", 32'(bus.ram_we), 32'(!c_vf && c_xfer && c_in && bus.host_we));
            if (c_vf) chk("ram_addr_video", 32'(bus.ram_addr), f_addr(bus.hpos, bus.vpos));
            else if (c_xfer && c_in) chk("ram_addr_host", 32'(bus.ram_addr), 32'(bus.host_addr));
            if (!c_vf && c_xfer && c_in && bus.host_we)
                chk("ram_wdata", 32'(bus.ram_wdata), 32'(bus.host_wdata));
            chk("rvalid", 32'(bus.host_rvalid), 32'(e_rv[c_slot]));
            if (e_rv[c_slot]) hold = e_rd[c_slot];
            chk("rdata", 32'(bus.host_rdata), 32'(hold));
            chk("rgb", 32'({bus.r, bus.g, bus.b}),
                e_vis[c_slot] ? 32'(f_rgb(e_pix[c_slot])) : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beam(input int h, input int v, input bit vis);
        bus.hpos    = 10'(h);
        bus.vpos    = 10'(v);
        bus.visible = vis;
    endtask

    task automatic host(input bit valid, input bit we, input int addr, input int wdata);
        bus.host_valid = valid;
        bus.host_we    = we;
        bus.host_addr  = ADDR_W'(addr);
        bus.host_wdata = 8'(wdata);
    endtask

    int n_en;
    int n_low;
    int waddr;
    int h;
    int v;

    initial begin
        beam(0, 0, 0);
        host(0, 0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("post_reset_rvalid", 32'(bus.host_rvalid), 0);
        chk("post_reset_rgb", 32'({bus.r, bus.g, bus.b}), 0);
        tick();

        // Preload two cells during blanking.
        host(1, 1, 0, 8'hE0);
        #1 chk("preload_ram_we", 32'(bus.ram_we), 1);
        tick();
        host(1, 1, 1, 8'h1F);
        tick();
        host(0, 0, 0, 0);
        tick();

        // Scanout of row 0, cells 0 and 1.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) beam(k, 0, 1);
            else beam(0, 0, 0);
            #1;
            if (k == 0) chk("scan_addr0", 32'(bus.ram_addr), 0);
            if (k == 4) chk("scan_addr1", 32'(bus.ram_addr), 1);
            if (k == 1) chk("scan_idle_en", 32'(bus.ram_en), 0);
            if (k >= 2 && k <= 5) chk("scan_cell0", 32'({bus.r, bus.g, bus.b}), 32'hFF0000);
            if (k >= 6) chk("scan_cell1", 32'({bus.r, bus.g, bus.b}), 32'h00FFFF);
            tick();
        end

        // Row addressing: exactly one fetch at address 162.
        n_en = 0;
        for (int k = 8; k < 12; k++) begin
            beam(k, 4, 1);
            #1;
            if (k == 8) chk("row_addr", 32'(bus.ram_addr), 162);
            if (bus.ram_en) n_en++;
            tick();
        end
        chk("row_fetch_count", 32'(n_en), 1);
        beam(0, 0, 0);

        // Host write then read at the last cell.
        host(1, 1, 19199, 8'h5A);
        tick();
        host(1, 0, 19199, 0);
        #1 chk("rd_ready", 32'(bus.host_ready), 1);
        tick();
        host(0, 0, 0, 0);
        #1 chk("rd_plus1_rvalid", 32'(bus.host_rvalid), 0);
        tick();
        #1 chk("rd_plus2_rvalid", 32'(bus.host_rvalid), 1);
        chk("rd_plus2_rdata", 32'(bus.host_rdata), 32'h5A);
        tick();
        #1 chk("rd_plus3_rvalid", 32'(bus.host_rvalid), 0);
        chk("rd_hold_rdata", 32'(bus.host_rdata), 32'h5A);
        tick();

        // Out-of-range write and read.
        host(1, 1, 19200, 8'h77);
        #1 chk("oor_wr_ram_en", 32'(bus.ram_en), 0);
        tick();
        host(1, 0, 19200, 0);
        tick();
        host(0, 0, 0, 0);
        tick();
        #1 chk("oor_rd_rvalid", 32'(bus.host_rvalid), 1);
        chk("oor_rd_rdata", 32'(bus.host_rdata), 0);
        tick();

        // Reset while a read is in flight.
        host(1, 0, 19199, 0);
        repeat (3) tick();
        host(1, 0, 19199, 0);
        tick();
        host(0, 0, 0, 0);
        #1 chk("pre_rst_rdata", 32'(bus.host_rdata), 32'h5A);
        tick();
        host(1, 0, 19199, 0);
        #1 chk("mid_ready", 32'(bus.host_ready), 1);
        tick();
        rst = 1'b1;
        host(0, 0, 0, 0);
        #1 chk("in_rst_ready", 32'(bus.host_ready), 0);
        chk("in_rst_rdata", 32'(bus.host_rdata), 0);
        tick();
        #1 chk("in_rst_rvalid", 32'(bus.host_rvalid), 0);
        tick();
        rst = 1'b0;
        #1 chk("rel_rvalid", 32'(bus.host_rvalid), 0);
        chk("rel_rdata", 32'(bus.host_rdata), 0);
        chk("rel_rgb", 32'({bus.r, bus.g, bus.b}), 0);
        tick();
        #1 chk("rel_plus1_rvalid", 32'(bus.host_rvalid), 0);
        tick();

        // Blanking: host owns every cycle.
        for (int k = 0; k < 20; k++) begin
            beam($urandom_range(640, 799), $urandom_range(0, 524), 0);
            host(1, $urandom_range(0, 1), $urandom_range(0, 700), $urandom_range(0, 255));
            #1 chk("blank_ready", 32'(bus.host_ready), 1);
            tick();
        end

        // Contention: host writes stream through a visible line of row 2.
        n_low = 0;
        waddr = 2000;
        for (int k = 0; k < 800; k++) begin
            beam(k, 8, k < 640);
            host(1, 1, waddr, $urandom_range(0, 255));
            #1;
            if (bus.host_ready) waddr++;
            else n_low++;
            tick();
        end
        chk("contention_stalls", 32'(n_low), 160);
        beam(700, 500, 0);
        for (int a = 2000; a < waddr; a++) begin
            host(1, 0, a, 0);
            tick();
        end
        host(0, 0, 0, 0);
        repeat (3) tick();

        // Random traffic over the top rows and the whole frame.
        for (int k = 0; k < 4000; k++) begin
            h = $urandom_range(0, 799);
            v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 524);
            beam(h, v, (h < 640) && (v < 480) && ($urandom_range(0, 7) != 0));
            case ($urandom_range(0, 9))
                0: host($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(19200, 32767),
                        $urandom_range(0, 255));
                1: host($urandom_range(0, 1), $urandom_range(0, 1), 19199, $urandom_range(0, 255));
                default: host($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 700),
                              $urandom_range(0, 255));
            endcase
            tick();
        end
        host(0, 0, 0, 0);
        beam(0, 0, 0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
